// File: rtl/dispenser_pkg.sv
// Shared constants and helpers for the dispense sequencer and its servo PWM generator.
package dispenser_pkg;

    localparam int unsigned NUM_SLOTS = 5;
    localparam int unsigned CNT_W     = 4;
    localparam logic [2:0]  SLOT_IDLE = 3'd7;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_LOAD       = 3'd1;
    localparam state_t ST_SELECT     = 3'd2;
    localparam state_t ST_WAIT_FRAME = 3'd3;
    localparam state_t ST_PUSH       = 3'd4;
    localparam state_t ST_RETURN     = 3'd5;
    localparam state_t ST_DONE       = 3'd6;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] count,
                                                     input logic [CNT_W-1:0] max_count);
        return (count > max_count) ? max_count : count;
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Free-running servo frame counter with one registered PWM comparator per slot.
module servo_pwm_gen
    import dispenser_pkg::*;
#(
    parameter int unsigned PWM_PERIOD = 1_000_000,
    parameter int unsigned CW         = $clog2(PWM_PERIOD)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SLOTS-1:0][CW-1:0] i_width,
    output logic [NUM_SLOTS-1:0]         o_servo_pwm,
    output logic                         o_frame_tick
);

    localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);

    logic [CW-1:0]        r_pwm_cnt;
    logic [NUM_SLOTS-1:0] r_servo_pwm;
    logic [NUM_SLOTS-1:0] w_pwm_d;

    assign o_frame_tick = (r_pwm_cnt == CNT_LAST);
    assign o_servo_pwm  = r_servo_pwm;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_pwm_d[i] = (r_pwm_cnt < i_width[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt   <= '0;
            r_servo_pwm <= '0;
        end else begin
            r_pwm_cnt   <= o_frame_tick ? '0 : r_pwm_cnt + 1'b1;
            r_servo_pwm <= w_pwm_d;
        end
    end

endmodule

// File: rtl/dispense_sequencer.sv
// Runs a dispense job over slots A..E, one pill push/return cycle at a time.
// Optional STOCK_SKIP_EN: skip slots with no stock and flag them in o_fault_mask.
module dispense_sequencer
    import dispenser_pkg::*;
#(
    parameter int unsigned PWM_PERIOD    = 1_000_000,
    parameter int unsigned PULSE_REST    = 50_000,
    parameter int unsigned PULSE_PUSH    = 100_000,
    parameter int unsigned HOLD_FRAMES   = 25,
    parameter int unsigned SETTLE_FRAMES = 25,
    parameter int unsigned MAX_COUNT     = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] i_dispenser_start,
    input  logic [CNT_W-1:0]     i_count_a,
    input  logic [CNT_W-1:0]     i_count_b,
    input  logic [CNT_W-1:0]     i_count_c,
    input  logic [CNT_W-1:0]     i_count_d,
    input  logic [CNT_W-1:0]     i_count_e,
    input  logic [NUM_SLOTS-1:0] i_stock_ok,
    output logic                 o_dispensing_active,
    output logic [NUM_SLOTS-1:0] o_servo_pwm,
    output logic [2:0]           o_cur_slot,
    output logic [CNT_W-1:0]     o_pills_left,
    output logic [NUM_SLOTS-1:0] o_fault_mask
);

    localparam int unsigned PWM_W      = $clog2(PWM_PERIOD);
    localparam int unsigned MAX_FRAMES = (HOLD_FRAMES > SETTLE_FRAMES) ? HOLD_FRAMES
                                                                       : SETTLE_FRAMES;
    localparam int unsigned FRAME_W    = $clog2(MAX_FRAMES + 1);

    localparam logic [PWM_W-1:0]   WIDTH_REST  = PWM_W'(PULSE_REST);
    localparam logic [PWM_W-1:0]   WIDTH_PUSH  = PWM_W'(PULSE_PUSH);
    localparam logic [FRAME_W-1:0] HOLD_LAST   = FRAME_W'(HOLD_FRAMES - 1);
    localparam logic [FRAME_W-1:0] SETTLE_LAST = FRAME_W'(SETTLE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   COUNT_MAX   = CNT_W'(MAX_COUNT);
    localparam logic [2:0]         PTR_END     = 3'(NUM_SLOTS);

    state_t               r_state;
    logic                 r_armed;
    logic                 r_active;
    logic [NUM_SLOTS-1:0] r_mask;
    logic [CNT_W-1:0]     r_count [NUM_SLOTS];
    logic [2:0]           r_ptr;
    logic [2:0]           r_cur_slot;
    logic [CNT_W-1:0]     r_pills_left;
    logic [FRAME_W-1:0]   r_frames;

    logic [NUM_SLOTS-1:0][PWM_W-1:0] w_width;
    logic                 w_frame_tick;
    logic [CNT_W-1:0]     w_count_in [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_nonzero;
    logic [CNT_W-1:0]     w_pills_dec;
    logic                 w_capture;
    logic                 w_skip;

    assign w_count_in[0] = i_count_a;
    assign w_count_in[1] = i_count_b;
    assign w_count_in[2] = i_count_c;
    assign w_count_in[3] = i_count_d;
    assign w_count_in[4] = i_count_e;

    assign w_capture   = (r_state == ST_IDLE) && r_armed && (|i_dispenser_start);
    assign w_pills_dec = r_pills_left - 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_nonzero[i] = (w_count_in[i] != '0);
            w_width[i]   = ((r_state == ST_PUSH) && (r_cur_slot == 3'(i))) ? WIDTH_PUSH
                                                                            : WIDTH_REST;
        end
    end

`ifdef STOCK_SKIP_EN
    logic [NUM_SLOTS-1:0] r_fault_mask;

    assign w_skip       = r_mask[r_ptr] && !i_stock_ok[r_ptr];
    assign o_fault_mask = r_fault_mask;

    always_ff @(posedge clk) begin
        if (rst || w_capture) begin
            r_fault_mask <= '0;
        end else if ((r_state == ST_SELECT) && (r_ptr != PTR_END) && w_skip) begin
            r_fault_mask[r_ptr] <= 1'b1;
        end
    end
`else
    logic w_unused_stock;

    assign w_unused_stock = ^i_stock_ok;
    assign w_skip         = 1'b0;
    assign o_fault_mask   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_armed      <= 1'b1;
            r_active     <= 1'b0;
            r_mask       <= '0;
            r_ptr        <= '0;
            r_cur_slot   <= SLOT_IDLE;
            r_pills_left <= '0;
            r_frames     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) r_count[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_mask  <= i_dispenser_start & w_nonzero;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            r_count[i] <= clamp_count(w_count_in[i], COUNT_MAX);
                        end
                        r_armed <= 1'b0;
                        r_state <= ST_LOAD;
                    end else if (i_dispenser_start == '0) begin
                        // A held request must be released before another job can start.
                        r_armed <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_active <= 1'b1;
                    r_ptr    <= '0;
                    r_state  <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (r_ptr == PTR_END) begin
                        r_state <= ST_DONE;
                    end else if (!r_mask[r_ptr] || w_skip) begin
                        r_ptr <= r_ptr + 3'd1;
                    end else begin
                        r_cur_slot   <= r_ptr;
                        r_pills_left <= r_count[r_ptr];
                        r_frames     <= '0;
                        r_state      <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (w_frame_tick) r_state <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (w_frame_tick) begin
                        if (r_frames == HOLD_LAST) begin
                            r_frames <= '0;
                            r_state  <= ST_RETURN;
                        end else begin
                            r_frames <= r_frames + 1'b1;
                        end
                    end
                end
                ST_RETURN: begin
                    if (w_frame_tick) begin
                        if (r_frames == SETTLE_LAST) begin
                            r_frames     <= '0;
                            r_pills_left <= w_pills_dec;
                            if (w_pills_dec != '0) begin
                                r_state <= ST_PUSH;
                            end else begin
                                r_ptr   <= r_ptr + 3'd1;
                                r_state <= ST_SELECT;
                            end
                        end else begin
                            r_frames <= r_frames + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_active   <= 1'b0;
                    r_cur_slot <= SLOT_IDLE;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_dispensing_active = r_active;
    assign o_cur_slot          = r_cur_slot;
    assign o_pills_left        = r_pills_left;

    servo_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .CW         (PWM_W)
    ) u_servo_pwm_gen (
        .clk          (clk),
        .rst          (rst),
        .i_width      (w_width),
        .o_servo_pwm  (o_servo_pwm),
        .o_frame_tick (w_frame_tick)
    );

endmodule
